// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronise, debounce, press/release pulses
// and optional auto-repeat fire strobes for N independent channels.
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             master_clk,
    input  logic             BTN_Reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_fire
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        HOLD_REPEAT
    } rpt_state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [DW-1:0]          cnt_q;
        logic [DW-1:0]          cnt_d;
        logic                   accept;
        logic                   rise;
        logic                   fall;
        logic                   level_q;
        logic                   press_q;
        logic                   release_q;
        logic                   fire_q;
        rpt_state_t             state_q;
        rpt_state_t             state_d;
        logic [RW-1:0]          r_q;
        logic [RW-1:0]          r_d;
        logic                   strobe;

        assign s    = sync_q[SYNC_STAGES-1];
        assign rise = accept & s;
        assign fall = accept & ~s;

        // Counter only advances while s disagrees with the accepted level
        always_comb begin
            cnt_d  = cnt_q;
            accept = 1'b0;
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_d  = '0;
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end

        always_comb begin
            state_d = state_q;
            r_d     = r_q;
            strobe  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HOLD_DELAY;
                        r_d     = '0;
                    end
                end
                HOLD_DELAY: begin
                    if (fall) begin
                        state_d = IDLE;
                    end else if (!repeat_en[i]) begin
                        r_d = '0;
                    end else if (r_q == RD_LAST) begin
                        strobe  = 1'b1;
                        r_d     = '0;
                        state_d = HOLD_REPEAT;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
                HOLD_REPEAT: begin
                    if (fall) begin
                        state_d = IDLE;
                    end else if (!repeat_en[i]) begin
                        r_d     = '0;
                        state_d = HOLD_DELAY;
                    end else if (r_q == RP_LAST) begin
                        strobe = 1'b1;
                        r_d    = '0;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    r_d     = '0;
                end
            endcase
        end

        always_ff @(posedge master_clk or posedge BTN_Reset) begin
            if (BTN_Reset) begin
                sync_q    <= '0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                fire_q    <= 1'b0;
                state_q   <= IDLE;
                r_q       <= '0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
                cnt_q     <= cnt_d;
                level_q   <= accept ? s : level_q;
                press_q   <= rise;
                release_q <= fall;
                fire_q    <= rise | strobe;
                state_q   <= state_d;
                r_q       <= r_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_fire[i]    = fire_q;
    end

endmodule
